// File: rtl/rtl_settings_pkg.sv
// Shared memory-tester types: expected-write descriptor, data modes, error codes
// and the pattern LFSR step used by both transmitter and checker.
package rtl_settings_pkg;

  localparam int PKT_ADDR_W  = 32;
  localparam int PKT_BURST_W = 11;
  localparam int PKT_OFF_W   = 3;

  localparam logic [7:0] LFSR_SEED = 8'hFF;

  typedef enum logic {
    FIX_DATA = 1'b0,
    RND_DATA = 1'b1
  } data_mode_t;

  typedef enum logic [1:0] {
    ERR_MISMATCH   = 2'd0,
    ERR_UNEXPECTED = 2'd1,
    ERR_OVERFLOW   = 2'd2
  } err_type_t;

  typedef struct packed {
    logic [PKT_ADDR_W-1:0]  start_addr;
    logic [PKT_BURST_W-1:0] words_count;
    logic [PKT_OFF_W-1:0]   start_off;
    logic [PKT_OFF_W-1:0]   end_off;
    data_mode_t             data_mode;
    logic [7:0]             data_ptrn;
  } cmp_pkt_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[6] ^ s[1] ^ s[0]};
  endfunction

endpackage

// File: rtl/cmp_pkt_fifo.sv
// Synchronous descriptor FIFO; a push while full is accepted only when a pop
// frees a slot in the same cycle. Flags are registered.
module cmp_pkt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && !empty_q;
    do_push  = push_i && (!full_q || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/compare_block.sv
// Read-side checker: queues expected-write descriptors, regenerates the expected
// data per word and compares it against read-return beats under the byte mask.
module compare_block
  import rtl_settings_pkg::*;
#(
  parameter int AMM_DATA_W     = 64,
  parameter int AMM_ADDR_W     = PKT_ADDR_W,
  parameter int AMM_BURST_W    = PKT_BURST_W,
  parameter int PKT_FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_test_i,
  input  logic                  cmp_pkt_en_i,
  input  cmp_pkt_t              cmp_pkt_i,
  input  logic                  readdatavalid_i,
  input  logic [AMM_DATA_W-1:0] readdata_i,
  output logic                  cmp_busy_o,
  output logic                  cmp_idle_o,
  output logic                  error_check_o,
  output logic                  err_flag_o,
  output logic [1:0]            err_type_o,
  output logic [AMM_ADDR_W-1:0] err_addr_o,
  output logic [AMM_DATA_W-1:0] err_data_o,
  output logic [AMM_DATA_W-1:0] err_exp_o
);

  localparam int DATA_B_W = AMM_DATA_W / 8;
  localparam int ADDR_B_W = $clog2(DATA_B_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  function automatic logic [DATA_B_W-1:0] byte_mask(
    input logic                first,
    input logic                last,
    input logic [ADDR_B_W-1:0] s_off,
    input logic [ADDR_B_W-1:0] e_off
  );
    logic [DATA_B_W-1:0] m;
    for (int i = 0; i < DATA_B_W; i++) begin
      m[i] = (!first || (i >= int'(s_off))) && (!last || (i <= int'(e_off)));
    end
    return m;
  endfunction

  state_t                 state_q, state_d;
  logic [AMM_ADDR_W-1:0]  pkt_addr_q, pkt_addr_d;
  logic [ADDR_B_W-1:0]    start_off_q, start_off_d;
  logic [ADDR_B_W-1:0]    end_off_q, end_off_d;
  data_mode_t             mode_q, mode_d;
  logic [7:0]             ptrn_q, ptrn_d;
  logic [AMM_BURST_W-1:0] word_cnt_q, word_cnt_d;
  logic [AMM_BURST_W-1:0] word_idx_q, word_idx_d;
  logic [7:0]             lfsr_q, lfsr_d;
  logic                   err_flag_q, err_flag_d;
  logic                   err_pulse_q, err_pulse_d;
  err_type_t              err_type_q, err_type_d;
  logic [AMM_ADDR_W-1:0]  err_addr_q, err_addr_d;
  logic [AMM_DATA_W-1:0]  err_data_q, err_data_d;
  logic [AMM_DATA_W-1:0]  err_exp_q, err_exp_d;

  logic                   fifo_push, fifo_pop;
  logic                   fifo_full, fifo_empty;
  cmp_pkt_t               fifo_head;

  logic [7:0]             exp_byte;
  logic [AMM_DATA_W-1:0]  exp_word;
  logic [DATA_B_W-1:0]    bmask;
  logic [AMM_DATA_W-1:0]  bit_mask;
  logic                   mismatch;
  logic                   beat_last;
  logic [AMM_ADDR_W-1:0]  cur_addr;
  logic                   load_head;
  logic                   mism_err, unexp_err, ovf_err;

  cmp_pkt_fifo #(
    .WIDTH ($bits(cmp_pkt_t)),
    .DEPTH (PKT_FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (start_test_i),
    .push_i  (fifo_push),
    .data_i  (cmp_pkt_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    exp_byte  = (mode_q == RND_DATA) ? lfsr_q : ptrn_q;
    exp_word  = {DATA_B_W{exp_byte}};
    beat_last = (word_cnt_q == AMM_BURST_W'(1));
    bmask     = byte_mask(word_idx_q == '0, beat_last, start_off_q, end_off_q);
    bit_mask  = '0;
    for (int i = 0; i < DATA_B_W; i++) begin
      bit_mask[i*8 +: 8] = {8{bmask[i]}};
    end
    mismatch  = |((readdata_i ^ exp_word) & bit_mask);
    cur_addr  = pkt_addr_q + (AMM_ADDR_W'(word_idx_q) << ADDR_B_W);
  end

  always_comb begin
    state_d     = state_q;
    pkt_addr_d  = pkt_addr_q;
    start_off_d = start_off_q;
    end_off_d   = end_off_q;
    mode_d      = mode_q;
    ptrn_d      = ptrn_q;
    word_cnt_d  = word_cnt_q;
    word_idx_d  = word_idx_q;
    lfsr_d      = lfsr_q;
    err_flag_d  = err_flag_q;
    err_pulse_d = 1'b0;
    err_type_d  = err_type_q;
    err_addr_d  = err_addr_q;
    err_data_d  = err_data_q;
    err_exp_d   = err_exp_q;
    fifo_push   = cmp_pkt_en_i && (state_q != ST_ERROR);
    fifo_pop    = 1'b0;
    load_head   = 1'b0;
    mism_err    = 1'b0;
    unexp_err   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (readdatavalid_i) begin
          unexp_err = 1'b1;
        end else if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          load_head = 1'b1;
        end
      end
      ST_CHECK: begin
        if (readdatavalid_i) begin
          if (mismatch) begin
            mism_err = 1'b1;
          end else begin
            lfsr_d     = lfsr_next(lfsr_q);
            word_idx_d = word_idx_q + 1'b1;
            word_cnt_d = word_cnt_q - 1'b1;
            // Chaining straight into the next head keeps back-to-back bursts gapless.
            if (beat_last) begin
              if (!fifo_empty) begin
                fifo_pop  = 1'b1;
                load_head = 1'b1;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
      end
      ST_ERROR: begin
        fifo_push = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ovf_err = fifo_push && fifo_full && !fifo_pop;

    if (load_head) begin
      state_d     = ST_CHECK;
      pkt_addr_d  = AMM_ADDR_W'(fifo_head.start_addr);
      start_off_d = ADDR_B_W'(fifo_head.start_off);
      end_off_d   = ADDR_B_W'(fifo_head.end_off);
      mode_d      = fifo_head.data_mode;
      ptrn_d      = fifo_head.data_ptrn;
      lfsr_d      = fifo_head.data_ptrn;
      word_idx_d  = '0;
      word_cnt_d  = (fifo_head.words_count == '0) ? AMM_BURST_W'(1)
                                                  : AMM_BURST_W'(fifo_head.words_count);
    end

    if (mism_err) begin
      err_type_d = ERR_MISMATCH;
      err_addr_d = cur_addr;
      err_data_d = readdata_i;
      err_exp_d  = exp_word;
    end else if (unexp_err) begin
      err_type_d = ERR_UNEXPECTED;
      err_addr_d = '0;
      err_data_d = readdata_i;
      err_exp_d  = '0;
    end else if (ovf_err) begin
      err_type_d = ERR_OVERFLOW;
      err_addr_d = AMM_ADDR_W'(cmp_pkt_i.start_addr);
      err_data_d = '0;
      err_exp_d  = '0;
    end

    if (mism_err || unexp_err || ovf_err) begin
      err_flag_d  = 1'b1;
      err_pulse_d = 1'b1;
      state_d     = ST_ERROR;
    end

    if (start_test_i) begin
      state_d     = ST_IDLE;
      fifo_push   = 1'b0;
      fifo_pop    = 1'b0;
      word_cnt_d  = '0;
      word_idx_d  = '0;
      lfsr_d      = LFSR_SEED;
      err_flag_d  = 1'b0;
      err_pulse_d = 1'b0;
      err_type_d  = ERR_MISMATCH;
      err_addr_d  = '0;
      err_data_d  = '0;
      err_exp_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      pkt_addr_q  <= '0;
      start_off_q <= '0;
      end_off_q   <= '0;
      mode_q      <= FIX_DATA;
      ptrn_q      <= '0;
      word_cnt_q  <= '0;
      word_idx_q  <= '0;
      lfsr_q      <= LFSR_SEED;
      err_flag_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      err_type_q  <= ERR_MISMATCH;
      err_addr_q  <= '0;
      err_data_q  <= '0;
      err_exp_q   <= '0;
    end else begin
      state_q     <= state_d;
      pkt_addr_q  <= pkt_addr_d;
      start_off_q <= start_off_d;
      end_off_q   <= end_off_d;
      mode_q      <= mode_d;
      ptrn_q      <= ptrn_d;
      word_cnt_q  <= word_cnt_d;
      word_idx_q  <= word_idx_d;
      lfsr_q      <= lfsr_d;
      err_flag_q  <= err_flag_d;
      err_pulse_q <= err_pulse_d;
      err_type_q  <= err_type_d;
      err_addr_q  <= err_addr_d;
      err_data_q  <= err_data_d;
      err_exp_q   <= err_exp_d;
    end
  end

  assign cmp_busy_o    = fifo_full;
  assign cmp_idle_o    = fifo_empty && (state_q == ST_IDLE);
  assign error_check_o = err_pulse_q;
  assign err_flag_o    = err_flag_q;
  assign err_type_o    = err_type_q;
  assign err_addr_o    = err_addr_q;
  assign err_data_o    = err_data_q;
  assign err_exp_o     = err_exp_q;

endmodule
